// File: rtl/mem_responder_if.sv
// Request/response types and the memreq/memresp bus between the load/store
// stage (master) and the on-chip memory responder (slave).
package mem_responder_pkg;

  typedef enum logic [1:0] {
    MEMREQ_READ  = 2'd0,
    MEMREQ_WRITE = 2'd1
  } memreq_mode_t;

  typedef struct packed {
    memreq_mode_t mode;
    logic [31:0]  addr;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
  } memreq_t;

  typedef struct packed {
    logic [31:0] data;
  } memresp_t;

endpackage

interface mem_responder_if;
  import mem_responder_pkg::*;

  logic     request_enable;
  memreq_t  request;
  logic     response_enable;
  memresp_t response;
  logic     access_fault;
  logic     busy;

  modport master (
    output request_enable, request,
    input  response_enable, response, access_fault, busy
  );

  modport slave (
    input  request_enable, request,
    output response_enable, response, access_fault, busy
  );

endinterface

// File: rtl/mem_responder.sv
// Word-organised on-chip RAM behind the memreq/memresp bus: one request at a
// time, byte-strobed writes, word reads, one response LATENCY cycles later.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int          ADDR_WIDTH = 14,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          LATENCY    = 2,
  parameter string       INIT_FILE  = ""
) (
  input logic            clk,
  input logic            rst,
  mem_responder_if.slave bus
);

  localparam logic [32:0] SPAN = 33'(4) << ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                  state;
  logic [3:0]              count;
  logic                    pend;
  logic                    is_write_q;
  logic                    hit_q;
  logic [ADDR_WIDTH-1:0]   index_q;
  logic [31:0]             wdata_q;
  logic [3:0]              wstrb_q;
  logic [31:0]             rd_hold;
  logic [31:0]             resp_data;
  logic                    resp_en;
  logic                    fault;
  logic                    busy_q;

  logic [31:0]             ram [2**ADDR_WIDTH];

  logic [31:0]             offset;
  logic                    hit;
  logic                    is_write;
  logic [ADDR_WIDTH-1:0]   index;
  logic [31:0]             acc_val;
  logic [31:0]             rd_val;

  if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
    $error("mem_responder: LATENCY must be within 1..8");
  end

  // The subtraction-then-compare form keeps the upper bound from wrapping past 2**32.
  always_comb begin
    offset   = bus.request.addr - BASE_ADDR;
    hit      = (bus.request.addr >= BASE_ADDR) && ({1'b0, offset} < SPAN);
    is_write = (bus.request.mode == MEMREQ_WRITE);
    index    = offset[ADDR_WIDTH+1:2];
    acc_val  = (!is_write && hit) ? ram[index] : 32'h0;
    rd_val   = (!is_write_q && hit_q) ? ram[index_q] : 32'h0;
  end

  // The commit edge is the one right after acceptance; reset clears pend so an uncommitted write is lost.
  always_ff @(posedge clk) begin
    if (pend && is_write_q && hit_q) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_q[i]) ram[index_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      count      <= 4'd0;
      pend       <= 1'b0;
      is_write_q <= 1'b0;
      hit_q      <= 1'b0;
      index_q    <= '0;
      wdata_q    <= 32'h0;
      wstrb_q    <= 4'h0;
      rd_hold    <= 32'h0;
      resp_data  <= 32'h0;
      resp_en    <= 1'b0;
      fault      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      pend    <= 1'b0;
      resp_en <= 1'b0;
      fault   <= 1'b0;
      if (pend) rd_hold <= rd_val;
      case (state)
        IDLE: begin
          if (bus.request_enable) begin
            is_write_q <= is_write;
            hit_q      <= hit;
            index_q    <= index;
            wdata_q    <= bus.request.wdata;
            wstrb_q    <= bus.request.wstrb;
            pend       <= 1'b1;
            busy_q     <= 1'b1;
            if (LATENCY == 1) begin
              state     <= RESP;
              resp_en   <= 1'b1;
              fault     <= !hit;
              resp_data <= acc_val;
            end else begin
              state <= WAIT;
              count <= 4'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          if (count == 4'd1) begin
            state     <= RESP;
            count     <= 4'd0;
            resp_en   <= 1'b1;
            fault     <= !hit_q;
            resp_data <= pend ? rd_val : rd_hold;
          end else begin
            count <= count - 4'd1;
          end
        end
        RESP: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.response_enable = resp_en;
  assign bus.response.data   = resp_data;
  assign bus.access_fault    = fault;
  assign bus.busy            = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomised and directed bench for mem_responder: three instances with
// different latency/size/base, checked against a word-map reference model.
module tb_mem_responder;
  import mem_responder_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mem_responder_if bus_a ();
  mem_responder_if bus_b ();
  mem_responder_if bus_c ();

  mem_responder #(.ADDR_WIDTH(14), .BASE_ADDR(32'h0000_0000), .LATENCY(2), .INIT_FILE(""))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  mem_responder #(.ADDR_WIDTH(6), .BASE_ADDR(32'h0000_0000), .LATENCY(3), .INIT_FILE(""))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b));
  mem_responder #(.ADDR_WIDTH(4), .BASE_ADDR(32'h0000_0100), .LATENCY(1), .INIT_FILE(""))
    dut_c (.clk(clk), .rst(rst), .bus(bus_c));

  int check_count = 0;
  int error_count = 0;
  logic [31:0] model_mem [longint];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  function automatic int lat_of(input int which);
    return (which == 0) ? 2 : (which == 1) ? 3 : 1;
  endfunction

  function automatic int aw_of(input int which);
    return (which == 0) ? 14 : (which == 1) ? 6 : 4;
  endfunction

  function automatic longint base_of(input int which);
    return (which == 2) ? 64'h100 : 64'h0;
  endfunction

  function automatic bit model_hit(input int which, input logic [31:0] addr);
    longint a = {32'b0, addr};
    longint span = 64'd4 << aw_of(which);
    return (a >= base_of(which)) && (a < base_of(which) + span);
  endfunction

  function automatic longint key_of(input int which, input logic [31:0] addr);
    return (longint'(which) << 40) + ({32'b0, addr} - base_of(which)) / 4;
  endfunction

  // Reference: a word map updated by strobe-merge; reads of in-range words return the map entry.
  task automatic model_apply(input int which, input logic [1:0] mode, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] wstrb,
                             output logic [31:0] exp_data, output logic exp_fault);
    bit hit = model_hit(which, addr);
    longint k;
    logic [31:0] cur;
    exp_fault = !hit;
    exp_data  = 32'h0;
    if (!hit) return;
    k = key_of(which, addr);
    cur = model_mem.exists(k) ? model_mem[k] : 32'h0;
    if (mode == 2'd1) begin
      for (int i = 0; i < 4; i++) if (wstrb[i]) cur[8*i +: 8] = wdata[8*i +: 8];
      model_mem[k] = cur;
    end else begin
      exp_data = cur;
    end
  endtask

  task automatic drive_req(input int which, input logic en, input logic [1:0] mode,
                           input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
    memreq_t r;
    r.mode  = memreq_mode_t'(mode);
    r.addr  = addr;
    r.wdata = wdata;
    r.wstrb = wstrb;
    case (which)
      0: begin bus_a.request = r; bus_a.request_enable = en; end
      1: begin bus_b.request = r; bus_b.request_enable = en; end
      default: begin bus_c.request = r; bus_c.request_enable = en; end
    endcase
  endtask

  task automatic sample_bus(input int which, output logic en, output logic [31:0] data,
                            output logic fault, output logic busy);
    case (which)
      0: begin en = bus_a.response_enable; data = bus_a.response.data; fault = bus_a.access_fault; busy = bus_a.busy; end
      1: begin en = bus_b.response_enable; data = bus_b.response.data; fault = bus_b.access_fault; busy = bus_b.busy; end
      default: begin en = bus_c.response_enable; data = bus_c.response.data; fault = bus_c.access_fault; busy = bus_c.busy; end
    endcase
  endtask

  // One request for a single cycle, then LATENCY+2 samples on falling edges.
  task automatic applyStimulus(input int which, input logic [1:0] mode, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] wstrb, input string tag);
    int lat = lat_of(which);
    logic [31:0] exp_data, data, data_resp, data_hold;
    logic exp_fault, en, fault, busy, fault_resp;
    logic [31:0] en_bits, busy_bits, exp_en, exp_busy;
    model_apply(which, mode, addr, wdata, wstrb, exp_data, exp_fault);
    en_bits = 0;
    busy_bits = 0;
    data_resp = 32'h0;
    data_hold = 32'h0;
    fault_resp = 1'b0;
    drive_req(which, 1'b1, mode, addr, wdata, wstrb);
    @(negedge clk);
    drive_req(which, 1'b0, mode, addr, wdata, wstrb);
    for (int s = 1; s <= lat + 2; s++) begin
      sample_bus(which, en, data, fault, busy);
      en_bits[s] = en;
      busy_bits[s] = busy;
      if (s == lat) begin data_resp = data; fault_resp = fault; end
      if (s == lat + 2) data_hold = data;
      if (s < lat + 2) @(negedge clk);
    end
    exp_en = 32'd1 << lat;
    exp_busy = ((32'd1 << (lat + 1)) - 32'd1) & ~32'd1;
    checkOutput({tag, ".pulse"}, en_bits, exp_en);
    checkOutput({tag, ".busy"}, busy_bits, exp_busy);
    checkOutput({tag, ".data"}, data_resp, exp_data);
    checkOutput({tag, ".fault"}, {31'b0, fault_resp}, {31'b0, exp_fault});
    checkOutput({tag, ".hold"}, data_hold, exp_data);
  endtask

  // request_enable held for 20 cycles: expected accept/response/busy windows built from the pacing rule.
  task automatic stream_test();
    int lat = lat_of(1);
    int accepted[$];
    int resp_cnt = 0;
    logic [31:0] exp_data, data, obs_en, obs_busy, exp_en, exp_busy;
    logic exp_fault, en, fault, busy;
    model_apply(1, 2'd0, 32'h0, 32'h0, 4'h0, exp_data, exp_fault);
    obs_en = 0;
    obs_busy = 0;
    drive_req(1, 1'b1, 2'd0, 32'h0, 32'h0, 4'h0);
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      sample_bus(1, en, data, fault, busy);
      obs_en[k] = en;
      obs_busy[k] = busy;
      if (en) begin
        resp_cnt++;
        checkOutput("stream.data", data, exp_data);
      end
      if (k == 20) drive_req(1, 1'b0, 2'd0, 32'h0, 32'h0, 4'h0);
    end
    for (int t = 1; t <= 20; t += lat + 1) accepted.push_back(t);
    exp_en = 0;
    exp_busy = 0;
    foreach (accepted[i]) begin
      exp_en[accepted[i] + lat - 1] = 1'b1;
      for (int k = accepted[i]; k < accepted[i] + lat; k++) exp_busy[k] = 1'b1;
    end
    checkOutput("stream.count", resp_cnt, accepted.size());
    checkOutput("stream.pulses", obs_en, exp_en);
    checkOutput("stream.busy", obs_busy, exp_busy);
  endtask

  // Write to 0x30 on the latency-3 instance, reset either before or after its commit edge.
  task automatic reset_test(input bool_after, input string tag);
    logic en, fault, busy;
    logic [31:0] data;
    int pulses = 0;
    drive_req(1, 1'b1, 2'd1, 32'h30, 32'h0000_0055, 4'hF);
    @(negedge clk);
    drive_req(1, 1'b0, 2'd1, 32'h30, 32'h0000_0055, 4'hF);
    if (bool_after) begin
      @(negedge clk);
      model_mem[key_of(1, 32'h30)] = 32'h0000_0055;
    end
    rst = 1'b1;
    #1;
    sample_bus(1, en, data, fault, busy);
    checkOutput({tag, ".busy_in_reset"}, {31'b0, busy}, 32'h0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 1) rst = 1'b0;
      sample_bus(1, en, data, fault, busy);
      if (en) pulses++;
    end
    checkOutput({tag, ".no_response"}, pulses, 0);
    applyStimulus(1, 2'd0, 32'h30, 32'h0, 4'h0, {tag, ".read"});
  endtask

  logic [31:0] rnd_addr;
  logic en_r, fault_r, busy_r;
  logic [31:0] data_r;

  initial begin
    rst = 1'b1;
    for (int w = 0; w < 3; w++) drive_req(w, 1'b0, 2'd0, 32'h0, 32'h0, 4'h0);
    repeat (3) @(negedge clk);
    for (int w = 0; w < 3; w++) begin
      sample_bus(w, en_r, data_r, fault_r, busy_r);
      checkOutput($sformatf("reset%0d.outputs", w), {data_r[27:0], en_r, fault_r, busy_r, 1'b0},
                  32'h0);
      checkOutput($sformatf("reset%0d.data_hi", w), {28'b0, data_r[31:28]}, 32'h0);
    end
    rst = 1'b0;
    $display("[TB] reset released");

    applyStimulus(0, 2'd1, 32'h10, 32'hDEAD_BEEF, 4'hF, "a.wr10");
    applyStimulus(0, 2'd0, 32'h10, 32'h0, 4'h0, "a.rd10");
    applyStimulus(0, 2'd1, 32'h20, 32'h1122_3344, 4'hF, "a.wr20");
    applyStimulus(0, 2'd1, 32'h21, 32'h0000_AA00, 4'b0010, "a.wr21_lane1");
    applyStimulus(0, 2'd0, 32'h20, 32'h0, 4'h0, "a.rd20");
    applyStimulus(0, 2'd1, 32'h20, 32'hFFFF_FFFF, 4'b0000, "a.wr20_nostrb");
    applyStimulus(0, 2'd0, 32'h22, 32'h0, 4'h0, "a.rd20_again");
    applyStimulus(0, 2'd3, 32'h10, 32'h0, 4'h0, "a.mode3_read");

    applyStimulus(1, 2'd1, 32'h0, 32'hCAFE_F00D, 4'hF, "b.wr0");
    stream_test();
    applyStimulus(1, 2'd1, 32'h30, 32'h0BAD_F00D, 4'hF, "b.wr30");
    reset_test(1'b0, "b.rst_early");
    reset_test(1'b1, "b.rst_late");

    for (int i = 0; i < 16; i++)
      applyStimulus(2, 2'd1, 32'h100 + 32'(4 * i), $urandom, 4'hF, "c.fill");
    applyStimulus(2, 2'd0, 32'hFC, 32'h0, 4'h0, "c.rd_below");
    applyStimulus(2, 2'd0, 32'h140, 32'h0, 4'h0, "c.rd_above");
    applyStimulus(2, 2'd1, 32'h140, 32'h1234_5678, 4'hF, "c.wr_above");
    applyStimulus(2, 2'd0, 32'h100, 32'h0, 4'h0, "c.rd_word0");
    applyStimulus(2, 2'd0, 32'h13C, 32'h0, 4'h0, "c.rd_last");
    applyStimulus(2, 2'd0, 32'hFFFF_FFFC, 32'h0, 4'h0, "c.rd_top");

    for (int i = 0; i < 8; i++)
      applyStimulus(0, 2'd1, 32'h1000 + 32'(4 * i), $urandom, 4'hF, "a.init");
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 7) == 0) rnd_addr = 32'h0001_0000 | $urandom;
      else rnd_addr = 32'h1000 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
      applyStimulus(0, 2'($urandom_range(0, 3)), rnd_addr, $urandom, 4'($urandom_range(0, 15)),
                    $sformatf("a.rand%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
